if_next_pc_unit: RTL and testbench

//  Fetch-side consumer of the ID->IF branch bus (taken, 32-bit target).

---
 rtl/if_next_pc_unit_if.sv | 21 ++
 rtl/if_next_pc_unit.sv | 136 +++++++++++++
 tb/tb_if_next_pc_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_next_pc_unit_if.sv
// Fetch request handshake between the next-PC unit (master) and the IF stage (slave).
interface if_next_pc_unit_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_program_count;
  logic        fetch_address_error;

  modport master (
    output fetch_valid,
    output fetch_program_count,
    output fetch_address_error,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_program_count,
    input  fetch_address_error,
    output fetch_ready
  );
endinterface

// File: rtl/if_next_pc_unit.sv
// Next-PC unit: owns the fetch PC and issues instruction-fetch requests.
// Orders branches so the delay slot is always fetched before the target,
// and lets WB flush redirects (exception/ERET) win over everything but reset.
// Optional macro IF_FETCH_ALIGN_CHECK_EN: flag a misaligned request, present it
// once, then stall (fetch_valid=0) until a flush redirect arrives.
module if_next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [32:0]                branch_bus,           // {taken, target}
  input  logic [31:0]                branch_program_count,
  input  logic                       flush_valid,
  input  logic [31:0]                flush_target,
  if_next_pc_unit_if.master          fetch
);

  typedef enum logic [1:0] {
    SEQ       = 2'd0,
    WAIT_SLOT = 2'd1,
    REDIRECT  = 2'd2,
    STALL     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] last_issued_q, last_issued_d;
  logic [31:0] target_q, target_d;
  logic [31:0] slot_pc_q, slot_pc_d;

  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] branch_slot_pc;
  logic        accept;

  assign branch_taken   = branch_bus[32];
  assign branch_target  = branch_bus[31:0];
  assign branch_slot_pc = branch_program_count + 32'd4;
  assign accept         = valid_q & fetch.fetch_ready;

  // Next-state, next-PC and redirect bookkeeping
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    last_issued_d = last_issued_q;
    target_d      = target_q;
    slot_pc_d     = slot_pc_q;

    if (accept) begin
      last_issued_d = pc_q;
      pc_d          = pc_q + PC_STEP;
    end

    case (state_q)
      SEQ: begin
        if (branch_taken) begin
          target_d  = branch_target;
          slot_pc_d = branch_slot_pc;
          if (last_issued_q == branch_slot_pc) begin
            // Slot already out: jump now, dropping any unaccepted sequential request.
            pc_d    = branch_target;
            state_d = REDIRECT;
          end else if (accept && (pc_q == branch_slot_pc)) begin
            // Slot is being accepted this very cycle, so there is nothing left to wait for.
            pc_d    = branch_target;
            state_d = REDIRECT;
          end else begin
            state_d = WAIT_SLOT;
          end
        end
      end
      WAIT_SLOT: begin
        if (accept && (pc_q == slot_pc_q)) begin
          pc_d    = target_q;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (accept) state_d = SEQ;
      end
      STALL: begin
        pc_d          = pc_q;
        last_issued_d = last_issued_q;
      end
      default: state_d = SEQ;
    endcase

`ifdef IF_FETCH_ALIGN_CHECK_EN
    // Misaligned request has gone out once; freeze until WB redirects.
    if (accept && (|pc_q[1:0])) begin
      pc_d    = pc_q;
      state_d = STALL;
    end
`endif

    if (flush_valid) begin
      pc_d    = flush_target;
      state_d = SEQ;
    end

    valid_d = (state_d != STALL);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEQ;
      valid_q       <= 1'b0;
      pc_q          <= RESET_PC;
      last_issued_q <= '0;
      target_q      <= '0;
      slot_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      last_issued_q <= last_issued_d;
      target_q      <= target_d;
      slot_pc_q     <= slot_pc_d;
    end
  end

  // Request outputs
  always_comb begin
    fetch.fetch_valid         = valid_q;
    fetch.fetch_program_count = pc_q;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    fetch.fetch_address_error = valid_q & (|pc_q[1:0]);
`else
    fetch.fetch_address_error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_if_next_pc_unit.sv
// Directed table-driven bench for if_next_pc_unit. Each record holds the inputs
// driven during one cycle and the outputs expected during that same cycle.
module tb_if_next_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [32:0] branch_bus;
  logic [31:0] branch_program_count;
  logic        flush_valid;
  logic [31:0] flush_target;

  if_next_pc_unit_if fif ();

  if_next_pc_unit #(.RESET_PC(32'hbfc0_0000), .PC_STEP(32'd4)) dut (
    .clock                (clock),
    .reset                (reset),
    .branch_bus           (branch_bus),
    .branch_program_count (branch_program_count),
    .flush_valid          (flush_valid),
    .flush_target         (flush_target),
    .fetch                (fif.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] bpc;
    logic        fl;
    logic [31:0] ft;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  task automatic add(input logic rst, input logic rdy, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] bpc,
                     input logic fl, input logic [31:0] ft,
                     input logic ev, input logic [31:0] epc, input logic ee);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.tk = tk; v.tgt = tgt; v.bpc = bpc;
    v.fl = fl; v.ft = ft; v.exp_v = ev; v.exp_pc = epc; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ev, input logic [31:0] epc, input logic ee);
    tests++;
    if (fif.fetch_valid !== ev || fif.fetch_program_count !== epc || fif.fetch_address_error !== ee) begin
      fails++;
      $display("FAIL %s: got valid=%0b pc=%08h err=%0b, expected valid=%0b pc=%08h err=%0b",
               name, fif.fetch_valid, fif.fetch_program_count, fif.fetch_address_error, ev, epc, ee);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; branch_bus = '0; branch_program_count = '0;
    flush_valid = 1'b0; flush_target = '0; fif.fetch_ready = 1'b1;
  endtask

  initial begin
    int  waited;
    bit  seen;
    // rst rdy tk tgt bpc fl ft | valid pc err
    add(0,1,0,0,0,0,0, 0,32'hbfc00000,0);                       // r0 reset state
    add(0,1,0,0,0,0,0, 1,32'hbfc00000,0);                       // r1
    add(0,1,0,0,0,0,0, 1,32'hbfc00004,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00008,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc0000c,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00010,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00014,0);                       // r6
    add(0,0,1,32'hbfc00100,32'hbfc00010,0,0, 1,32'hbfc00018,0); // r7 slot issued, not accepted
    add(0,1,1,32'hbfc00900,32'hbfc000fc,0,0, 1,32'hbfc00100,0); // r8 taken ignored in REDIRECT
    add(0,0,1,32'hbfc00200,32'hbfc00100,0,0, 1,32'hbfc00104,0); // r9 slot pending
    add(0,1,0,0,0,0,0, 1,32'hbfc00104,0);                       // r10 slot accepted
    add(0,0,0,0,0,0,0, 1,32'hbfc00200,0);                       // r11 ready low
    add(0,0,0,0,0,0,0, 1,32'hbfc00200,0);
    add(0,0,0,0,0,0,0, 1,32'hbfc00200,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00200,0);                       // r14
    add(0,1,1,32'hbfc00500,32'hbfc001fc,1,32'hbfc00380, 1,32'hbfc00204,0); // r15 flush beats branch
    add(0,1,0,0,0,0,0, 1,32'hbfc00380,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00384,0);
    add(0,1,1,32'hbfc00102,32'hbfc00380,0,0, 1,32'hbfc00388,0); // r18 misaligned target
    add(0,1,0,0,0,0,0, 1,32'hbfc00102,ALIGN);                   // r19
    if (ALIGN) begin
      add(0,1,0,0,0,0,0, 0,32'hbfc00102,0);
      add(0,1,0,0,0,0,0, 0,32'hbfc00102,0);
      add(0,1,0,0,0,1,32'hbfc00400, 0,32'hbfc00102,0);
    end else begin
      add(0,1,0,0,0,0,0, 1,32'hbfc00106,0);
      add(0,1,0,0,0,0,0, 1,32'hbfc0010a,0);
      add(0,1,0,0,0,1,32'hbfc00400, 1,32'hbfc0010e,0);
    end
    add(0,1,0,0,0,0,0, 1,32'hbfc00400,0);                       // r23
    add(1,1,0,0,0,1,32'hbfc00600, 1,32'hbfc00404,0);            // r24 reset beats flush
    add(0,1,0,0,0,0,0, 0,32'hbfc00000,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00000,0);
    add(0,1,0,0,0,0,0, 1,32'hbfc00004,0);                       // r27

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);

    foreach (vecs[i]) begin
      reset                = vecs[i].rst;
      fif.fetch_ready      = vecs[i].rdy;
      branch_bus           = {vecs[i].tk, vecs[i].tgt};
      branch_program_count = vecs[i].bpc;
      flush_valid          = vecs[i].fl;
      flush_target         = vecs[i].ft;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_err);
      @(negedge clock);
    end

    // Long ready-low hold: address must not move.
    drive_idle();
    fif.fetch_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      #1 check($sformatf("hold%0d", k), 1'b1, 32'hbfc00008, 1'b0);
      @(negedge clock);
    end

    // 32-bit wrap of the sequential increment.
    flush_valid = 1'b1; flush_target = 32'hffff_fffc;
    @(negedge clock);
    drive_idle();
    #1 check("wrap_pre", 1'b1, 32'hffff_fffc, 1'b0);
    @(negedge clock);
    #1 check("wrap_post", 1'b1, 32'h0000_0000, 1'b0);

    // Restart after reset, waiting a bounded number of cycles for a valid request.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 8) begin
      @(negedge clock);
      #1 if (fif.fetch_valid === 1'b1) seen = 1'b1;
      waited++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL restart_timeout: got fetch_valid=%0b, expected 1 within 8 cycles", fif.fetch_valid);
    end else begin
      check("restart", 1'b1, 32'hbfc00000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
